mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_pick.sv | 38 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter slice.
//   state_t            : arbiter FSM encoding (IDLE -> ISSUE -> RESP)
//   NREQ               : number of requesters
//   REQ_DBG/CPU/AUX    : requester index constants
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam int unsigned NREQ = 3;

  localparam logic [1:0] REQ_DBG = 2'd0;
  localparam logic [1:0] REQ_CPU = 2'd1;
  localparam logic [1:0] REQ_AUX = 2'd2;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection.
//   req       : request vector (NREQ bits)
//   start     : index where the circular search begins (0..NREQ-1)
//   grant_oh  : one-hot winner (all zero when no request)
//   grant_idx : binary winner index (0 when no request)
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      start,
  output logic [NREQ-1:0] grant_oh,
  output logic [1:0]      grant_idx
);

  logic       found;
  logic [2:0] sum;
  logic [1:0] cand;

  // Walk the requesters starting at 'start', wrapping past the last index.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = {1'b0, start} + 3'(i);
      if (sum >= 3'(NREQ)) sum = sum - 3'(NREQ);
      cand = sum[1:0];
      if (!found && req[cand]) begin
        found          = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester memory bus arbiter (debug, CPU, auxiliary).
// One transaction per 3 cycles: IDLE (arbitrate/capture), ISSUE (mem_op
// strobe), RESP (ack + rdata passthrough of mem_do).
// Ports:
//   clk, n_reset           : clock, asynchronous active-low reset
//   req/req_adr/req_wren/req_wdata : per-requester request bundles (slice i)
//   ack, rdata             : one-cycle completion strobe, read data
//   mem_op/mem_adr/mem_wren/mem_di/mem_do : memory bus
//   busy                   : FSM not in IDLE
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority 0 > 1 > 2.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [2:0]        req,
  input  logic [3*AW-1:0]   req_adr,
  input  logic [3*4-1:0]    req_wren,
  input  logic [3*DW-1:0]   req_wdata,
  output logic [2:0]        ack,
  output logic [DW-1:0]     rdata,
  output logic              mem_op,
  output logic [AW-1:0]     mem_adr,
  output logic [3:0]        mem_wren,
  output logic [DW-1:0]     mem_di,
  input  logic [DW-1:0]     mem_do,
  output logic              busy
);

  state_t          state_q, state_d;
  logic [1:0]      grant_q;
  logic [AW-1:0]   adr_q;
  logic [3:0]      wren_q;
  logic [DW-1:0]   wdata_q;

  logic [1:0]      start;
  logic [NREQ-1:0] pick_oh;
  logic [1:0]      pick_idx;
  logic [AW-1:0]   sel_adr;
  logic [3:0]      sel_wren;
  logic [DW-1:0]   sel_wdata;
  logic            capture;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q;

  assign start = (ptr_q == REQ_AUX) ? REQ_DBG : ptr_q + 2'd1;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)     ptr_q <= REQ_DBG;
    else if (capture) ptr_q <= pick_idx;
  end
`else
  assign start = REQ_DBG;
`endif

  arb_pick u_pick (
    .req       (req),
    .start     (start),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx)
  );

  // AND-OR mux of the winning requester's bundle.
  always_comb begin
    sel_adr   = '0;
    sel_wren  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sel_adr   = sel_adr   | (req_adr[i*AW +: AW]   & {AW{pick_oh[i]}});
      sel_wren  = sel_wren  | (req_wren[i*4 +: 4]    & {4{pick_oh[i]}});
      sel_wdata = sel_wdata | (req_wdata[i*DW +: DW] & {DW{pick_oh[i]}});
    end
  end

  assign capture = (state_q == ST_IDLE) && (|req);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      grant_q <= REQ_DBG;
      adr_q   <= '0;
      wren_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      grant_q <= pick_idx;
      adr_q   <= sel_adr;
      wren_q  <= sel_wren;
      wdata_q <= sel_wdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_op   = 1'b0;
    mem_wren = '0;
    ack      = '0;
    rdata    = '0;
    busy     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (|req) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_op   = 1'b1;
        mem_wren = wren_q;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        ack[grant_q] = 1'b1;
        rdata        = mem_do;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_adr = adr_q;
  assign mem_di  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            n_reset = 1'b0;
  logic [2:0]      req = '0;
  logic [3*AW-1:0] req_adr = '0;
  logic [3*4-1:0]  req_wren = '0;
  logic [3*DW-1:0] req_wdata = '0;
  logic [2:0]      ack;
  logic [DW-1:0]   rdata;
  logic            mem_op;
  logic [AW-1:0]   mem_adr;
  logic [3:0]      mem_wren;
  logic [DW-1:0]   mem_di;
  logic [DW-1:0]   mem_do = '0;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .n_reset(n_reset), .req(req), .req_adr(req_adr),
    .req_wren(req_wren), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
    .mem_op(mem_op), .mem_adr(mem_adr), .mem_wren(mem_wren), .mem_di(mem_di),
    .mem_do(mem_do), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; req_wren = '0; mem_do = '0;
    n_reset = 1'b0;
    tick(); tick();
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (ack !== 3'b000) begin n_bad++; $display("FAIL reset_ack: got %b want 000", ack); end
    n_cmp++; if (mem_op !== 1'b0) begin n_bad++; $display("FAIL reset_mem_op: got %b want 0", mem_op); end
    n_cmp++; if (mem_wren !== 4'h0) begin n_bad++; $display("FAIL reset_mem_wren: got %h want 0", mem_wren); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (mem_adr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_adr: got %h want 0", mem_adr); end
    n_cmp++; if (mem_di !== 32'h0) begin n_bad++; $display("FAIL reset_mem_di: got %h want 0", mem_di); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
  endtask

  task automatic test_single_read();
    do_reset();
    req_adr[1*AW +: AW] = 32'h0001_0010;
    req = 3'b010;
    n_cmp++; if (mem_op !== 1'b0) begin n_bad++; $display("FAIL rd_c1_mem_op: got %b want 0", mem_op); end
    tick(); // ISSUE
    n_cmp++; if (mem_op !== 1'b1) begin n_bad++; $display("FAIL rd_c2_mem_op: got %b want 1", mem_op); end
    n_cmp++; if (mem_adr !== 32'h0001_0010) begin n_bad++; $display("FAIL rd_c2_mem_adr: got %h want 00010010", mem_adr); end
    n_cmp++; if (mem_wren !== 4'h0) begin n_bad++; $display("FAIL rd_c2_mem_wren: got %h want 0", mem_wren); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_c2_busy: got %b want 1", busy); end
    mem_do = 32'hDEAD_BEEF;
    tick(); // RESP
    n_cmp++; if (ack !== 3'b010) begin n_bad++; $display("FAIL rd_c3_ack: got %b want 010", ack); end
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_c3_rdata: got %h want deadbeef", rdata); end
    n_cmp++; if (mem_op !== 1'b0) begin n_bad++; $display("FAIL rd_c3_mem_op: got %b want 0", mem_op); end
    req = 3'b000;
    tick(); // IDLE
    n_cmp++; if (ack !== 3'b000) begin n_bad++; $display("FAIL rd_c4_ack: got %b want 000", ack); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_c4_busy: got %b want 0", busy); end
    tick();
    n_cmp++; if (mem_op !== 1'b0) begin n_bad++; $display("FAIL rd_c5_mem_op: got %b want 0", mem_op); end
  endtask

  task automatic test_write();
    do_reset();
    req_adr[0 +: AW]   = 32'h0002_0004;
    req_wren[0 +: 4]   = 4'hF;
    req_wdata[0 +: DW] = 32'h1234_5678;
    req = 3'b001;
    n_cmp++; if (mem_wren !== 4'h0) begin n_bad++; $display("FAIL wr_idle_mem_wren: got %h want 0", mem_wren); end
    tick(); // ISSUE
    n_cmp++; if (mem_op !== 1'b1) begin n_bad++; $display("FAIL wr_mem_op: got %b want 1", mem_op); end
    n_cmp++; if (mem_wren !== 4'hF) begin n_bad++; $display("FAIL wr_mem_wren: got %h want f", mem_wren); end
    n_cmp++; if (mem_adr !== 32'h0002_0004) begin n_bad++; $display("FAIL wr_mem_adr: got %h want 00020004", mem_adr); end
    n_cmp++; if (mem_di !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_mem_di: got %h want 12345678", mem_di); end
    tick(); // RESP
    n_cmp++; if (ack !== 3'b001) begin n_bad++; $display("FAIL wr_ack: got %b want 001", ack); end
    n_cmp++; if (mem_wren !== 4'h0) begin n_bad++; $display("FAIL wr_resp_mem_wren: got %h want 0", mem_wren); end
    req = 3'b000;
    tick();
    n_cmp++; if (mem_wren !== 4'h0) begin n_bad++; $display("FAIL wr_after_mem_wren: got %h want 0", mem_wren); end
    n_cmp++; if (mem_adr !== 32'h0002_0004) begin n_bad++; $display("FAIL wr_hold_mem_adr: got %h want 00020004", mem_adr); end
    req_wren = '0;
  endtask

  task automatic test_contention();
    int order[3];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    order = '{1, 2, 0};
`else
    order = '{0, 1, 2};
`endif
    do_reset();
    req_adr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      logic [2:0]  exp_ack;
      logic [31:0] exp_adr;
      exp_ack = 3'b001 << order[k];
      exp_adr = 32'h100 * (order[k] + 1);
      tick(); // ISSUE
      n_cmp++; if (mem_adr !== exp_adr) begin n_bad++; $display("FAIL cont_adr[%0d]: got %h want %h", k, mem_adr, exp_adr); end
      tick(); // RESP
      n_cmp++; if (ack !== exp_ack) begin n_bad++; $display("FAIL cont_ack[%0d]: got %b want %b", k, ack, exp_ack); end
      req[order[k]] = 1'b0;
      tick(); // IDLE
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_busy[%0d]: got %b want 0", k, busy); end
    end
  endtask

  task automatic test_starvation();
    do_reset();
    req = 3'b011;
    for (int k = 0; k < 6; k++) begin
      logic [2:0] exp_ack;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_ack = (k % 2 == 0) ? 3'b010 : 3'b001;
`else
      exp_ack = 3'b001;
`endif
      tick(); // ISSUE
      tick(); // RESP
      n_cmp++; if (ack !== exp_ack) begin n_bad++; $display("FAIL starve_ack[%0d]: got %b want %b", k, ack, exp_ack); end
      req = req & ~exp_ack;
      tick(); // IDLE
      req = 3'b011;
    end
    req = 3'b000;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_in_issue();
    do_reset();
    req_adr[0 +: AW] = 32'hCAFE_0000;
    req = 3'b001;
    tick(); // ISSUE
    n_cmp++; if (mem_op !== 1'b1) begin n_bad++; $display("FAIL rst_pre_mem_op: got %b want 1", mem_op); end
    #2 n_reset = 1'b0;
    req = 3'b000;
    #1;
    n_cmp++; if (mem_op !== 1'b0) begin n_bad++; $display("FAIL rst_async_mem_op: got %b want 0", mem_op); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    n_cmp++; if (ack !== 3'b000) begin n_bad++; $display("FAIL rst_async_ack: got %b want 000", ack); end
    n_cmp++; if (mem_adr !== 32'h0) begin n_bad++; $display("FAIL rst_async_mem_adr: got %h want 0", mem_adr); end
    #3 n_reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (ack !== 3'b000) begin n_bad++; $display("FAIL rst_replay_ack[%0d]: got %b want 000", k, ack); end
      n_cmp++; if (mem_op !== 1'b0) begin n_bad++; $display("FAIL rst_replay_mem_op[%0d]: got %b want 0", k, mem_op); end
    end
  endtask

  task automatic test_dropped_request();
    do_reset();
    req_adr[2*AW +: AW] = 32'h0000_0AA0;
    req = 3'b100;
    tick(); // ISSUE
    tick(); // RESP
    req = 3'b000;
    #1;
    n_cmp++; if (ack !== 3'b100) begin n_bad++; $display("FAIL drop_resp_ack: got %b want 100", ack); end
    // Dropping even earlier, during ISSUE, must not lose the ack either.
    tick(); // IDLE
    req = 3'b100;
    tick(); // ISSUE
    req = 3'b000;
    tick(); // RESP
    n_cmp++; if (ack !== 3'b100) begin n_bad++; $display("FAIL drop_issue_ack: got %b want 100", ack); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (mem_op !== 1'b0) begin n_bad++; $display("FAIL drop_after_mem_op[%0d]: got %b want 0", k, mem_op); end
      n_cmp++; if (ack !== 3'b000) begin n_bad++; $display("FAIL drop_after_ack[%0d]: got %b want 000", k, ack); end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_starvation();
    test_reset_in_issue();
    test_dropped_request();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
